stack_ctrl_p: RTL and testbench
===============================

STACK_CTRL_P -- requirements
Module: stack_ctrl_p

Interface
REQ-001 Parameter DEPTH, default 16: stack capacity in entries, SHALL be at least 2.
REQ-002 Parameter WAIT_EN, default 1: 1 = honour mem_ready; 0 = mem_ready internally tied to 1.
REQ-003 Ports, in this order (one clock; reset asynchronous, active-low):
 clk  in  1  rising-edge clock
 rst_n  in  1  asynchronous active-low reset
 opcode  in  3  instruction opcode from IR: 000 add, 001 sub, 010 and, 011 not, 100 push, 101 pop, 110 jmp, 111 jz
 mem_ready  in  1  memory access completes this cycle
 IorD, srcA, srcB, lda, ldb, PCsrc, PCwrite, memRead, IRwrite, tos, pop, push, MtoS, PCwriteCond, memWrite  out  1 each  datapath controls
 ALUop  out  2  ALU function select
 sp_cnt  out  $clog2(DEPTH+1)  current stack occupancy
 fault  out  1  stack overflow/underflow detected; sticky
 state  out  4  current state encoding, for debug

Function
REQ-004 Moore FSM; every control output SHALL be 0 unless its state asserts it, except where REQ-006 and REQ-007 gate on mem_ready.
REQ-005 States and encoding: IF=0, TOS=1, RDMEM=2, PSHMEM=3, POP1=4, POP2=5, LDB=6, JMP=7, LDA=8, BR=9, ALUNOT=10, ALU=11, PSHRES=12, WRMEM=13, FAULT=14.
REQ-006 IF: memRead=1 every cycle; PCwrite=1 and IRwrite=1 only in the cycle mem_ready=1; srcA, srcB, IorD, PCsrc and ALUop are 0; advance to TOS on mem_ready=1, otherwise hold.
REQ-007 RDMEM: IorD=1 and memRead=1; advance to PSHMEM on mem_ready=1. WRMEM: IorD=1; memWrite=1 only while mem_ready=1; advance to IF on mem_ready=1.
REQ-008 TOS: tos=1.
REQ-009 TOS SHALL go to FAULT when a guard fails (REQ-014). Otherwise: 100 -> RDMEM, 110 -> JMP, 111 -> BR, all other opcodes -> POP1.
REQ-010 Fixed transitions: PSHMEM (MtoS, push) -> IF; JMP (PCsrc, PCwrite) -> IF; BR (PCsrc, PCwriteCond) -> IF; POP1 (pop) -> LDA.
REQ-011 LDA: lda=1; opcode 101 -> WRMEM, 011 -> ALUNOT, otherwise -> POP2.
REQ-012 POP2 (pop) -> LDB; LDB (ldb) -> ALU; ALU (ALUop=opcode[1:0]) -> PSHRES; ALUNOT (ALUop=2'b11) -> PSHRES; PSHRES (push) -> IF.
REQ-013 sp_cnt SHALL increment by 1 on each clock edge where push=1 and decrement by 1 on each edge where pop=1; push and pop are never asserted together.
REQ-014 Guards, evaluated in TOS on the sp_cnt value at that moment:
 - 100 requires sp_cnt < DEPTH;
 - 101, 011 and 111 require sp_cnt >= 1;
 - 000, 001 and 010 require sp_cnt >= 2;
 - 110 has no guard.
REQ-015 FAULT: all controls 0 and fault=1; FAULT is terminal until reset; sp_cnt frozen.
REQ-016 sp_cnt SHALL never wrap below 0 or exceed DEPTH.
REQ-017 With WAIT_EN=0: IF, RDMEM and WRMEM SHALL each last exactly one cycle; an add then takes 8 cycles, IF through PSHRES.

Reset
REQ-018 rst_n=0 SHALL immediately force state=IF, sp_cnt=0 and fault=0, including mid-instruction and mid-wait.
REQ-019 After rst_n deasserts, the first edge SHALL perform IF behaviour; outputs during reset are those of IF with mem_ready gating applied.

Structure
REQ-020 A shared package SHALL hold the state enum, the opcode localparams and the ALUop encodings.
REQ-021 The occupancy counter with its guard comparisons SHALL be a sub-module, stack_occ, parameterised by DEPTH.

Verification
REQ-022 WAIT_EN=1, IF held with mem_ready=0 for 3 cycles, then 1 -> memRead high for 4 cycles; PCwrite and IRwrite high in the 4th cycle only.
REQ-023 Reset, push (100) twice, then add (000) -> sp_cnt goes 1, 2, then 1; ALUop=00 in ALU; state sequence IF, TOS, POP1, LDA, POP2, LDB, ALU, PSHRES.
REQ-024 DEPTH=4, five pushes -> the fifth enters FAULT from TOS; sp_cnt=4; fault=1 and stays 1.
REQ-025 Reset, then pop (101) -> FAULT, sp_cnt=0; then not (011) with sp_cnt=1 -> ALUop=11 in ALUNOT and sp_cnt remains 1.
REQ-026 rst_n pulsed low while in WRMEM with mem_ready=0 -> state=0, sp_cnt=0 and memWrite=0 immediately, without waiting for a clock edge.
REQ-027 jmp (110) -> JMP with PCsrc=1 and PCwrite=1, then IF; jz (111) -> BR with PCwriteCond=1 and PCwrite=0.

Source files
------------

// File: rtl/stack_ctrl_p_pkg.sv
// Shared types for the stack-machine controller: state encoding, opcodes,
// ALU function selects and the operand-count guard used when decoding.
package stack_ctrl_p_pkg;

  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_TOS    = 4'd1,
    S_RDMEM  = 4'd2,
    S_PSHMEM = 4'd3,
    S_POP1   = 4'd4,
    S_POP2   = 4'd5,
    S_LDB    = 4'd6,
    S_JMP    = 4'd7,
    S_LDA    = 4'd8,
    S_BR     = 4'd9,
    S_ALUNOT = 4'd10,
    S_ALU    = 4'd11,
    S_PSHRES = 4'd12,
    S_WRMEM  = 4'd13,
    S_FAULT  = 4'd14
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_NOT  = 3'b011;
  localparam logic [2:0] OP_PUSH = 3'b100;
  localparam logic [2:0] OP_POP  = 3'b101;
  localparam logic [2:0] OP_JMP  = 3'b110;
  localparam logic [2:0] OP_JZ   = 3'b111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

  // True when the stack holds enough entries (or room) for the opcode.
  function automatic logic guard_ok(input logic [2:0] op, input logic room,
                                    input logic has_one, input logic has_two);
    logic ok;
    case (op)
      OP_PUSH:               ok = room;
      OP_POP, OP_NOT, OP_JZ: ok = has_one;
      OP_JMP:                ok = 1'b1;
      default:               ok = has_two;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/stack_occ.sv
// Stack occupancy counter with the capacity/operand-count flags that the
// controller checks before committing to an instruction.
module stack_occ #(
  parameter int DEPTH = 16,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  output logic [CW-1:0] sp_cnt,
  output logic          room,
  output logic          has_one,
  output logic          has_two
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] TWO_C   = CW'(2);

  assign room    = sp_cnt < DEPTH_C;
  assign has_one = sp_cnt != '0;
  assign has_two = sp_cnt >= TWO_C;

  // Saturating: the guards should already prevent overrun, this is a backstop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_cnt <= '0;
    end else if (push && !pop && room) begin
      sp_cnt <= sp_cnt + 1'b1;
    end else if (pop && !push && has_one) begin
      sp_cnt <= sp_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/stack_ctrl_p.sv
// Moore control FSM for a small stack machine datapath; stack overflow or
// underflow detected at decode parks the FSM in FAULT until reset.
module stack_ctrl_p
  import stack_ctrl_p_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int WAIT_EN = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [2:0]                 opcode,
  input  logic                       mem_ready,
  output logic                       IorD,
  output logic                       srcA,
  output logic                       srcB,
  output logic                       lda,
  output logic                       ldb,
  output logic                       PCsrc,
  output logic                       PCwrite,
  output logic                       memRead,
  output logic                       IRwrite,
  output logic                       tos,
  output logic                       pop,
  output logic                       push,
  output logic                       MtoS,
  output logic                       PCwriteCond,
  output logic                       memWrite,
  output logic [1:0]                 ALUop,
  output logic [$clog2(DEPTH+1)-1:0] sp_cnt,
  output logic                       fault,
  output logic [3:0]                 state
);

  state_t state_q, state_d;
  logic   rdy;
  logic   room, has_one, has_two;

  assign rdy   = (WAIT_EN != 0) ? mem_ready : 1'b1;
  assign state = state_q;
  assign fault = (state_q == S_FAULT);

  stack_occ #(.DEPTH(DEPTH)) u_occ (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .sp_cnt  (sp_cnt),
    .room    (room),
    .has_one (has_one),
    .has_two (has_two)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IF;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    IorD        = 1'b0;
    srcA        = 1'b0;
    srcB        = 1'b0;
    lda         = 1'b0;
    ldb         = 1'b0;
    PCsrc       = 1'b0;
    PCwrite     = 1'b0;
    memRead     = 1'b0;
    IRwrite     = 1'b0;
    tos         = 1'b0;
    pop         = 1'b0;
    push        = 1'b0;
    MtoS        = 1'b0;
    PCwriteCond = 1'b0;
    memWrite    = 1'b0;
    ALUop       = ALU_ADD;
    case (state_q)
      S_IF: begin
        memRead = 1'b1;
        PCwrite = rdy;
        IRwrite = rdy;
        if (rdy) state_d = S_TOS;
      end
      S_TOS: begin
        tos = 1'b1;
        if (!guard_ok(opcode, room, has_one, has_two)) state_d = S_FAULT;
        else if (opcode == OP_PUSH)                    state_d = S_RDMEM;
        else if (opcode == OP_JMP)                     state_d = S_JMP;
        else if (opcode == OP_JZ)                      state_d = S_BR;
        else                                           state_d = S_POP1;
      end
      S_RDMEM: begin
        IorD    = 1'b1;
        memRead = 1'b1;
        if (rdy) state_d = S_PSHMEM;
      end
      S_PSHMEM: begin
        MtoS    = 1'b1;
        push    = 1'b1;
        state_d = S_IF;
      end
      S_JMP: begin
        PCsrc   = 1'b1;
        PCwrite = 1'b1;
        state_d = S_IF;
      end
      S_BR: begin
        PCsrc       = 1'b1;
        PCwriteCond = 1'b1;
        state_d     = S_IF;
      end
      S_POP1: begin
        pop     = 1'b1;
        state_d = S_LDA;
      end
      S_LDA: begin
        lda = 1'b1;
        if (opcode == OP_POP)      state_d = S_WRMEM;
        else if (opcode == OP_NOT) state_d = S_ALUNOT;
        else                       state_d = S_POP2;
      end
      S_POP2: begin
        pop     = 1'b1;
        state_d = S_LDB;
      end
      S_LDB: begin
        ldb     = 1'b1;
        state_d = S_ALU;
      end
      S_ALU: begin
        ALUop   = opcode[1:0];
        state_d = S_PSHRES;
      end
      S_ALUNOT: begin
        ALUop   = ALU_NOT;
        state_d = S_PSHRES;
      end
      S_PSHRES: begin
        push    = 1'b1;
        state_d = S_IF;
      end
      S_WRMEM: begin
        IorD     = 1'b1;
        memWrite = rdy;
        if (rdy) state_d = S_IF;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
  end

endmodule

// File: tb/tb_stack_ctrl_p.sv
// Directed bench for stack_ctrl_p: one handshaking instance (DEPTH=4) and
// one instance with the memory handshake disabled (DEPTH=16).
module tb_stack_ctrl_p;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] opcode;
  logic       mem_ready;
  logic       IorD, srcA, srcB, lda, ldb, PCsrc, PCwrite, memRead, IRwrite;
  logic       tos, pop, push, MtoS, PCwriteCond, memWrite, fault;
  logic [1:0] ALUop;
  logic [2:0] sp_cnt;
  logic [3:0] state;

  logic [2:0] nw_opcode;
  logic       nw_ready;
  logic       nw_IorD, nw_srcA, nw_srcB, nw_lda, nw_ldb, nw_PCsrc, nw_PCwrite;
  logic       nw_memRead, nw_IRwrite, nw_tos, nw_pop, nw_push, nw_MtoS;
  logic       nw_PCwriteCond, nw_memWrite, nw_fault;
  logic [1:0] nw_ALUop;
  logic [4:0] nw_sp_cnt;
  logic [3:0] nw_state;

  int checks = 0;
  int failures = 0;

  logic [3:0] trace [0:19];
  logic [5:0] ctl   [0:19];
  int         n;

  always #5 clk = ~clk;

  stack_ctrl_p #(.DEPTH(4), .WAIT_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .IorD(IorD), .srcA(srcA), .srcB(srcB), .lda(lda), .ldb(ldb),
    .PCsrc(PCsrc), .PCwrite(PCwrite), .memRead(memRead), .IRwrite(IRwrite),
    .tos(tos), .pop(pop), .push(push), .MtoS(MtoS),
    .PCwriteCond(PCwriteCond), .memWrite(memWrite), .ALUop(ALUop),
    .sp_cnt(sp_cnt), .fault(fault), .state(state)
  );

  stack_ctrl_p #(.DEPTH(16), .WAIT_EN(0)) dut_nw (
    .clk(clk), .rst_n(rst_n), .opcode(nw_opcode), .mem_ready(nw_ready),
    .IorD(nw_IorD), .srcA(nw_srcA), .srcB(nw_srcB), .lda(nw_lda), .ldb(nw_ldb),
    .PCsrc(nw_PCsrc), .PCwrite(nw_PCwrite), .memRead(nw_memRead),
    .IRwrite(nw_IRwrite), .tos(nw_tos), .pop(nw_pop), .push(nw_push),
    .MtoS(nw_MtoS), .PCwriteCond(nw_PCwriteCond), .memWrite(nw_memWrite),
    .ALUop(nw_ALUop), .sp_cnt(nw_sp_cnt), .fault(nw_fault), .state(nw_state)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mem_ready = 1'b0;
    rst_n     = 1'b0;
    #2;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Runs one instruction from IF with memory always ready; records the state
  // and a control snapshot {PCsrc,PCwrite,PCwriteCond,memWrite,ALUop} per cycle.
  task automatic run_instr(input logic [2:0] op);
    mem_ready = 1'b1;
    opcode    = op;
    #1;
    n = 0;
    while (n < 20) begin
      trace[n] = state;
      ctl[n]   = {PCsrc, PCwrite, PCwriteCond, memWrite, ALUop};
      n++;
      step();
      if (state == 4'd0 || state == 4'd14) break;
    end
    chk("run_bound", int'(n < 20), 1);
  endtask

  task automatic nw_run(input logic [2:0] op, output int len);
    nw_opcode = op;
    #1;
    len = 0;
    do begin
      step();
      len++;
    end while (nw_state != 4'd0 && nw_state != 4'd14 && len < 20);
  endtask

  initial begin
    int len;
    rst_n     = 1'b1;
    opcode    = 3'b000;
    mem_ready = 1'b0;
    nw_opcode = 3'b000;
    nw_ready  = 1'b0;

    // Reset values, IF outputs with mem_ready low
    do_reset();
    chk("rst_state", state, 0);
    chk("rst_sp", sp_cnt, 0);
    chk("rst_fault", fault, 0);
    chk("rst_memread", memRead, 1);
    chk("rst_pcwrite", PCwrite, 0);

    // IF wait: three stalled cycles, accepted on the fourth
    opcode = 3'b110;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("wait_memread", memRead, 1);
      chk("wait_pcwrite", PCwrite, 0);
      chk("wait_irwrite", IRwrite, 0);
      step();
      chk("wait_hold", state, 0);
    end
    mem_ready = 1'b1;
    #1;
    chk("go_memread", memRead, 1);
    chk("go_pcwrite", PCwrite, 1);
    chk("go_irwrite", IRwrite, 1);
    step();
    chk("go_tos", state, 1);

    // push, push, add
    do_reset();
    run_instr(3'b100);
    chk("push1_sp", sp_cnt, 1);
    chk("push1_len", n, 4);
    run_instr(3'b100);
    chk("push2_sp", sp_cnt, 2);
    run_instr(3'b000);
    chk("add_len", n, 8);
    chk("add_s0", trace[0], 0);
    chk("add_s1", trace[1], 1);
    chk("add_s2", trace[2], 4);
    chk("add_s3", trace[3], 8);
    chk("add_s4", trace[4], 5);
    chk("add_s5", trace[5], 6);
    chk("add_s6", trace[6], 11);
    chk("add_s7", trace[7], 12);
    chk("add_aluop", ctl[6][1:0], 0);
    chk("add_sp", sp_cnt, 1);
    chk("add_end", state, 0);
    // sub needs two operands; only one left
    run_instr(3'b001);
    chk("sub_fault_state", state, 14);
    chk("sub_fault_sp", sp_cnt, 1);

    // jmp and jz
    do_reset();
    run_instr(3'b110);
    chk("jmp_len", n, 3);
    chk("jmp_state", trace[2], 7);
    chk("jmp_pcsrc_pcw", ctl[2][5:4], 2'b11);
    chk("jmp_back_if", state, 0);
    run_instr(3'b100);
    run_instr(3'b111);
    chk("jz_state", trace[2], 9);
    chk("jz_pcsrc", ctl[2][5], 1);
    chk("jz_pcwrite", ctl[2][4], 0);
    chk("jz_pcwc", ctl[2][3], 1);
    chk("jz_sp", sp_cnt, 1);

    // pop on empty stack faults; FAULT is sticky and quiet
    do_reset();
    run_instr(3'b101);
    chk("pop0_state", state, 14);
    chk("pop0_sp", sp_cnt, 0);
    chk("pop0_fault", fault, 1);
    step();
    step();
    chk("fault_sticky", fault, 1);
    chk("fault_memread", memRead, 0);

    // not with one operand, then pop through WRMEM
    do_reset();
    run_instr(3'b100);
    run_instr(3'b011);
    chk("not_len", n, 6);
    chk("not_state", trace[4], 10);
    chk("not_aluop", ctl[4][1:0], 3);
    chk("not_sp", sp_cnt, 1);
    run_instr(3'b101);
    chk("pop_len", n, 5);
    chk("pop_wrmem", trace[4], 13);
    chk("pop_memwrite", ctl[4][2], 1);
    chk("pop_sp", sp_cnt, 0);

    // DEPTH=4 overflow on fifth push
    do_reset();
    for (int i = 0; i < 4; i++) run_instr(3'b100);
    chk("full_sp", sp_cnt, 4);
    chk("full_fault", fault, 0);
    run_instr(3'b100);
    chk("ovf_len", n, 2);
    chk("ovf_state", state, 14);
    chk("ovf_sp", sp_cnt, 4);
    step();
    step();
    step();
    chk("ovf_sticky", fault, 1);
    chk("ovf_sp_frozen", sp_cnt, 4);

    // Asynchronous reset while stalled in WRMEM
    do_reset();
    run_instr(3'b100);
    run_instr(3'b100);
    mem_ready = 1'b1;
    opcode    = 3'b101;
    #1;
    for (int i = 0; i < 4; i++) step();
    mem_ready = 1'b0;
    #1;
    chk("wr_state", state, 13);
    chk("wr_memwrite_stall", memWrite, 0);
    chk("wr_sp", sp_cnt, 1);
    step();
    chk("wr_hold", state, 13);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_state", state, 0);
    chk("arst_sp", sp_cnt, 0);
    chk("arst_memwrite", memWrite, 0);
    chk("arst_memread", memRead, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // WAIT_EN=0: mem_ready tied low is ignored; push 4 cycles, add 8 cycles
    do_reset();
    chk("nw_if_pcwrite", nw_PCwrite, 1);
    nw_run(3'b100, len);
    chk("nw_push_len", len, 4);
    nw_run(3'b100, len);
    chk("nw_sp2", nw_sp_cnt, 2);
    nw_run(3'b000, len);
    chk("nw_add_len", len, 8);
    chk("nw_add_sp", nw_sp_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
